// File: rtl/lib_pkg.sv
// Shared types and constants for the memory arbiter.
package lib_pkg;

    localparam int STREAK_W = 4;
    localparam int PERF_W   = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    typedef enum logic {
        SRC_I = 1'b0,
        SRC_D = 1'b1
    } arb_src_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
        logic [PERF_W-1:0] r;
        if (v == {PERF_W{1'b1}}) begin
            r = v;
        end else begin
            r = v + {{(PERF_W-1){1'b0}}, 1'b1};
        end
        return r;
    endfunction

endpackage

// File: rtl/mem_arbiter_priority.sv
// Grant selection for the memory arbiter: data wins unless a pending fetch
// has already watched STARVE_MAX consecutive data grants go by.
module arb_priority
    import lib_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic                dm_req,
    input  logic                if_req,
    input  logic [STREAK_W-1:0] streak,
    output logic                gnt_valid,
    output arb_src_t            gnt_src
);

    localparam logic [STREAK_W-1:0] STARVE_LIM = STREAK_W'(STARVE_MAX);

    // Pick the winning requester for this IDLE cycle.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_src   = SRC_I;
        if (dm_req && (!if_req || (streak < STARVE_LIM))) begin
            gnt_valid = 1'b1;
            gnt_src   = SRC_D;
        end else if (if_req) begin
            gnt_valid = 1'b1;
            gnt_src   = SRC_I;
        end else begin
            gnt_valid = 1'b0;
            gnt_src   = SRC_I;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port variable-latency memory between the instruction
// fetch port and the data port. Optional performance counters are built
// when MEM_ARB_PERF_EN is defined.
module mem_arbiter
    import lib_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int IADDR      = 16,
    parameter int DADDR      = 16,
    parameter int AWIDTH     = 16,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [IADDR-1:0]  if_addr,
    output logic [WIDTH-1:0]  if_rdata,
    output logic              if_valid,
    input  logic              dm_req,
    input  logic [DADDR-1:0]  dm_addr,
    input  logic [WIDTH-1:0]  dm_wdata,
    input  logic [3:0]        dm_wr_en,
    output logic [WIDTH-1:0]  dm_rdata,
    output logic              dm_valid,
    output logic              mem_req,
    output logic [AWIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0]  mem_wdata,
    output logic [3:0]        mem_be,
    input  logic              mem_ack,
    input  logic [WIDTH-1:0]  mem_rdata,
    output logic              stall
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [PERF_W-1:0] perf_if_grants,
    output logic [PERF_W-1:0] perf_dm_grants,
    output logic [PERF_W-1:0] perf_stall_cycles
`endif
);

    arb_state_t          state_q,     state_d;
    logic [STREAK_W-1:0] streak_q,    streak_d;
    logic                mem_req_q,   mem_req_d;
    logic [AWIDTH-1:0]   mem_addr_q,  mem_addr_d;
    logic [WIDTH-1:0]    mem_wdata_q, mem_wdata_d;
    logic [3:0]          mem_be_q,    mem_be_d;
    logic [WIDTH-1:0]    if_rdata_q,  if_rdata_d;
    logic                if_valid_q,  if_valid_d;
    logic [WIDTH-1:0]    dm_rdata_q,  dm_rdata_d;
    logic                dm_valid_q,  dm_valid_d;

    logic                gnt_valid_s;
    arb_src_t            gnt_src_s;
    logic                take_i_s;
    logic                take_d_s;

    arb_priority #(
        .STARVE_MAX (STARVE_MAX)
    ) u_prio (
        .dm_req    (dm_req),
        .if_req    (if_req),
        .streak    (streak_q),
        .gnt_valid (gnt_valid_s),
        .gnt_src   (gnt_src_s)
    );

    assign take_i_s = (state_q == IDLE) && gnt_valid_s && (gnt_src_s == SRC_I);
    assign take_d_s = (state_q == IDLE) && gnt_valid_s && (gnt_src_s == SRC_D);

    // Next-state, memory-request and response logic of the arbiter FSM.
    always_comb begin
        state_d     = state_q;
        streak_d    = streak_q;
        mem_req_d   = mem_req_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        if_rdata_d  = if_rdata_q;
        if_valid_d  = 1'b0;
        dm_rdata_d  = dm_rdata_q;
        dm_valid_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (take_d_s) begin
                    state_d     = GNT_D;
                    mem_req_d   = 1'b1;
                    mem_addr_d  = AWIDTH'(dm_addr);
                    mem_wdata_d = dm_wdata;
                    mem_be_d    = dm_wr_en;
                    // Only data grants that overtake a waiting fetch count.
                    if (if_req && (streak_q != {STREAK_W{1'b1}})) begin
                        streak_d = streak_q + STREAK_W'(1'b1);
                    end else begin
                        streak_d = streak_q;
                    end
                end else if (take_i_s) begin
                    state_d     = GNT_I;
                    mem_req_d   = 1'b1;
                    mem_addr_d  = AWIDTH'(if_addr);
                    mem_wdata_d = {WIDTH{1'b0}};
                    mem_be_d    = 4'b0000;
                    streak_d    = {STREAK_W{1'b0}};
                end else begin
                    state_d = IDLE;
                end
            end
            GNT_I, GNT_D: begin
                if (mem_ack) begin
                    state_d     = RESP;
                    mem_req_d   = 1'b0;
                    mem_addr_d  = {AWIDTH{1'b0}};
                    mem_wdata_d = {WIDTH{1'b0}};
                    mem_be_d    = 4'b0000;
                    if (state_q == GNT_I) begin
                        if_rdata_d = mem_rdata;
                        if_valid_d = 1'b1;
                    end else begin
                        dm_valid_d = 1'b1;
                        // Stores complete without disturbing the last load value.
                        if (mem_be_q == 4'b0000) begin
                            dm_rdata_d = mem_rdata;
                        end else begin
                            dm_rdata_d = dm_rdata_q;
                        end
                    end
                end else begin
                    state_d = state_q;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d     = IDLE;
                mem_req_d   = 1'b0;
                mem_addr_d  = {AWIDTH{1'b0}};
                mem_wdata_d = {WIDTH{1'b0}};
                mem_be_d    = 4'b0000;
            end
        endcase
    end

    // Arbiter state and output registers; reset abandons any in-flight access.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            streak_q    <= {STREAK_W{1'b0}};
            mem_req_q   <= 1'b0;
            mem_addr_q  <= {AWIDTH{1'b0}};
            mem_wdata_q <= {WIDTH{1'b0}};
            mem_be_q    <= 4'b0000;
            if_rdata_q  <= {WIDTH{1'b0}};
            if_valid_q  <= 1'b0;
            dm_rdata_q  <= {WIDTH{1'b0}};
            dm_valid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            streak_q    <= streak_d;
            mem_req_q   <= mem_req_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
            if_rdata_q  <= if_rdata_d;
            if_valid_q  <= if_valid_d;
            dm_rdata_q  <= dm_rdata_d;
            dm_valid_q  <= dm_valid_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_be    = mem_be_q;
    assign if_rdata  = if_rdata_q;
    assign if_valid  = if_valid_q;
    assign dm_rdata  = dm_rdata_q;
    assign dm_valid  = dm_valid_q;

    // The pipeline must react in the same cycle a port starts waiting.
    assign stall = (if_req & ~if_valid_q) | (dm_req & ~dm_valid_q);

`ifdef MEM_ARB_PERF_EN
    logic [PERF_W-1:0] perf_if_q,    perf_if_d;
    logic [PERF_W-1:0] perf_dm_q,    perf_dm_d;
    logic [PERF_W-1:0] perf_stall_q, perf_stall_d;

    // Saturating grant and stall-cycle counters.
    always_comb begin
        perf_if_d    = perf_if_q;
        perf_dm_d    = perf_dm_q;
        perf_stall_d = perf_stall_q;
        if (take_i_s) begin
            perf_if_d = sat_inc(perf_if_q);
        end else begin
            perf_if_d = perf_if_q;
        end
        if (take_d_s) begin
            perf_dm_d = sat_inc(perf_dm_q);
        end else begin
            perf_dm_d = perf_dm_q;
        end
        if (stall) begin
            perf_stall_d = sat_inc(perf_stall_q);
        end else begin
            perf_stall_d = perf_stall_q;
        end
    end

    // Performance counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_if_q    <= {PERF_W{1'b0}};
            perf_dm_q    <= {PERF_W{1'b0}};
            perf_stall_q <= {PERF_W{1'b0}};
        end else begin
            perf_if_q    <= perf_if_d;
            perf_dm_q    <= perf_dm_d;
            perf_stall_q <= perf_stall_d;
        end
    end

    assign perf_if_grants    = perf_if_q;
    assign perf_dm_grants    = perf_dm_q;
    assign perf_stall_cycles = perf_stall_q;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a memory model checks each request
// against the expected grant order, and a monitor checks every valid pulse
// against per-port response queues.
module tb_mem_arbiter;

    logic        clk;
    logic        reset;
    logic        if_req;
    logic [15:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_valid;
    logic        dm_req;
    logic [15:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [3:0]  dm_wr_en;
    logic [31:0] dm_rdata;
    logic        dm_valid;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        stall;
`ifdef MEM_ARB_PERF_EN
    logic [31:0] perf_if_grants;
    logic [31:0] perf_dm_grants;
    logic [31:0] perf_stall_cycles;
`endif

    mem_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_valid  (if_valid),
        .dm_req    (dm_req),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_wr_en  (dm_wr_en),
        .dm_rdata  (dm_rdata),
        .dm_valid  (dm_valid),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .stall     (stall)
`ifdef MEM_ARB_PERF_EN
        ,
        .perf_if_grants    (perf_if_grants),
        .perf_dm_grants    (perf_dm_grants),
        .perf_stall_cycles (perf_stall_cycles)
`endif
    );

    typedef struct packed {
        logic [15:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } gexp_t;

    gexp_t       gq[$];
    logic [31:0] ifq[$];
    logic [31:0] dmq[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int ack_cyc = 0;
    int lat   = 1;
    bit spur  = 1'b0;
    int stall_cnt = 0;
    logic [31:0] last_load = 32'h0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Bench-side count of cycles in which the pipeline is stalled.
    always @(posedge clk) begin
        if (reset) stall_cnt = 0;
        else if (stall) stall_cnt++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mem_fn(input logic [15:0] a);
        if (a == 16'h0040) return 32'h0000_0013;
        return {16'hC0DE, a};
    endfunction

    // Memory model: acks after lat cycles of mem_req, checks request fields.
    initial begin : memory_model
        int    wait_cnt;
        gexp_t held;
        gexp_t e;
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        wait_cnt  = 0;
        held      = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                mem_ack  = 1'b0;
                wait_cnt = 0;
            end else if (mem_req) begin
                wait_cnt++;
                if (wait_cnt == 1) begin
                    held = {mem_addr, mem_be, mem_wdata};
                    if (gq.size() == 0) begin
                        chk("unexpected_grant", {16'h0, mem_addr}, 32'hFFFF_FFFF);
                    end else begin
                        e = gq.pop_front();
                        chk("mem_addr", {16'h0, mem_addr}, {16'h0, e.addr});
                        chk("mem_be", {28'h0, mem_be}, {28'h0, e.be});
                        chk("mem_wdata", mem_wdata, e.wdata);
                    end
                end else begin
                    chk("hold_addr", {16'h0, mem_addr}, {16'h0, held.addr});
                    chk("hold_be_wdata", mem_wdata ^ {28'h0, mem_be}, held.wdata ^ {28'h0, held.be});
                end
                if (wait_cnt == lat) begin
                    mem_ack   = 1'b1;
                    mem_rdata = mem_fn(mem_addr);
                    ack_cyc   = cyc;
                end else begin
                    mem_ack = 1'b0;
                end
            end else begin
                wait_cnt  = 0;
                mem_ack   = spur;
                mem_rdata = spur ? 32'hBAD0_BAD0 : 32'h0;
                spur      = 1'b0;
            end
        end
    end

    // Monitor: pop and compare whenever a valid pulse is presented.
    always @(negedge clk) begin
        if (!reset) begin
            if (if_valid) begin
                if (ifq.size() == 0) chk("unexpected_if_valid", 32'h1, 32'h0);
                else chk("if_rdata", if_rdata, ifq.pop_front());
                chk("if_latency", cyc, ack_cyc + 1);
            end
            if (dm_valid) begin
                if (dmq.size() == 0) chk("unexpected_dm_valid", 32'h1, 32'h0);
                else chk("dm_rdata", dm_rdata, dmq.pop_front());
                chk("dm_latency", cyc, ack_cyc + 1);
            end
        end
    end

    task automatic fetch(input logic [15:0] a, input logic [31:0] d,
                         input bit chk_stall, input bit keep, input bit gpush);
        bit got;
        if (gpush) gq.push_back({a, 4'h0, 32'h0});
        ifq.push_back(d);
        if_req  = 1'b1;
        if_addr = a;
        #1;
        if (chk_stall) chk("stall_on_if_req", {31'h0, stall}, 32'h1);
        got = 1'b0;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            if (if_valid) got = 1'b1;
            else if (chk_stall) chk("stall_if_wait", {31'h0, stall}, 32'h1);
        end
        if (!got) chk("if_timeout", 32'h0, 32'h1);
        else if (chk_stall) chk("stall_at_if_valid", {31'h0, stall}, 32'h0);
        if (!keep) if_req = 1'b0;
    endtask

    task automatic data(input logic [15:0] a, input logic [31:0] wd, input logic [3:0] be,
                        input logic [31:0] exp, input bit keep, input bit gpush);
        bit got;
        if (gpush) gq.push_back({a, be, wd});
        dmq.push_back(exp);
        dm_req   = 1'b1;
        dm_addr  = a;
        dm_wdata = wd;
        dm_wr_en = be;
        got = 1'b0;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            if (dm_valid) got = 1'b1;
        end
        if (!got) chk("dm_timeout", 32'h0, 32'h1);
        if (!keep) dm_req = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        reset = 1'b1; if_req = 1'b0; if_addr = 16'h0;
        dm_req = 1'b0; dm_addr = 16'h0; dm_wdata = 32'h0; dm_wr_en = 4'h0;
        repeat (2) @(negedge clk);
        chk("rst_mem_req", {31'h0, mem_req}, 32'h0);
        chk("rst_mem_addr", {16'h0, mem_addr}, 32'h0);
        chk("rst_valids", {30'h0, if_valid, dm_valid}, 32'h0);
        chk("rst_rdata", if_rdata | dm_rdata, 32'h0);
        chk("rst_stall", {31'h0, stall}, 32'h0);
        reset = 1'b0;
        @(negedge clk);

        // Single fetch with zero-wait memory.
        lat = 1;
        fetch(16'h0040, 32'h0000_0013, 1'b1, 1'b0, 1'b1);
        @(negedge clk);

        // A load to set dm_rdata, then a store that must leave it alone.
        data(16'h0080, 32'h0, 4'b0000, 32'hC0DE_0080, 1'b0, 1'b1);
        last_load = 32'hC0DE_0080;
        @(negedge clk);
        data(16'h0100, 32'hDEAD_BEEF, 4'b0011, last_load, 1'b0, 1'b1);
        @(negedge clk);

        // Contention: expected grant order D,D,D,D,I,D,D,D,D,I.
        for (int k = 0; k < 4; k++) gq.push_back({16'h0200 + 16'(4*k), 4'h0, 32'h0});
        gq.push_back({16'h1000, 4'h0, 32'h0});
        for (int k = 4; k < 8; k++) gq.push_back({16'h0200 + 16'(4*k), 4'h0, 32'h0});
        gq.push_back({16'h1004, 4'h0, 32'h0});
        fork
            begin
                for (int k = 0; k < 8; k++)
                    data(16'h0200 + 16'(4*k), 32'h0, 4'h0, {16'hC0DE, 16'h0200 + 16'(4*k)}, k < 7, 1'b0);
            end
            begin
                fetch(16'h1000, 32'hC0DE_1000, 1'b0, 1'b1, 1'b0);
                fetch(16'h1004, 32'hC0DE_1004, 1'b0, 1'b0, 1'b0);
            end
        join
        last_load = 32'hC0DE_021C;
        @(negedge clk);

        // Slow memory: ack after 5 cycles of mem_req, then a spurious ack.
        lat = 5;
        data(16'h0300, 32'h0, 4'h0, 32'hC0DE_0300, 1'b0, 1'b1);
        last_load = 32'hC0DE_0300;
        @(negedge clk);
        spur = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("spurious_ack_valid", {30'h0, if_valid, dm_valid}, 32'h0);
        end
        chk("spurious_keeps_dm_rdata", dm_rdata, last_load);
        lat = 1;

        // Reset two cycles into a data grant.
        lat = 10;
        gq.push_back({16'h0400, 4'h0, 32'h0});
        dm_req = 1'b1; dm_addr = 16'h0400; dm_wr_en = 4'h0; dm_wdata = 32'h0;
        for (int i = 0; i < 10 && !mem_req; i++) @(negedge clk);
        chk("gnt_d_reached", {31'h0, mem_req}, 32'h1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("midrst_mem_req", {31'h0, mem_req}, 32'h0);
        chk("midrst_mem_addr", {16'h0, mem_addr}, 32'h0);
        chk("midrst_mem_wdata_be", mem_wdata | {28'h0, mem_be}, 32'h0);
        chk("midrst_valids", {30'h0, if_valid, dm_valid}, 32'h0);
        chk("midrst_rdata", if_rdata | dm_rdata, 32'h0);
        dm_req = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        lat = 1;
        last_load = 32'h0;
        @(negedge clk);

        // After reset: 3 fetches and 2 loads granted normally.
        fetch(16'h0044, 32'hC0DE_0044, 1'b1, 1'b0, 1'b1);
        fetch(16'h0048, 32'hC0DE_0048, 1'b0, 1'b0, 1'b1);
        fetch(16'h004C, 32'hC0DE_004C, 1'b0, 1'b0, 1'b1);
        data(16'h0500, 32'h0, 4'h0, 32'hC0DE_0500, 1'b0, 1'b1);
        data(16'h0504, 32'h0, 4'h0, 32'hC0DE_0504, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
`ifdef MEM_ARB_PERF_EN
        chk("perf_if_grants", perf_if_grants, 32'd3);
        chk("perf_dm_grants", perf_dm_grants, 32'd2);
        chk("perf_stall_cycles", perf_stall_cycles, stall_cnt);
`endif

        chk("gq_drained", gq.size(), 32'd0);
        chk("ifq_drained", ifq.size(), 32'd0);
        chk("dmq_drained", dmq.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-port, variable-latency memory between the core's instruction-fetch port and its data port.
- Sits between the riscv core's imem/dmem interfaces and a unified memory.
- Serialises requests, gives data priority with an anti-starvation limit, and drives a stall to the pipeline while either port is waiting.

Parameters:
WIDTH, 32, data/instruction word width
IADDR, 16, instruction address width
DADDR, 16, data address width
AWIDTH, 16, memory address width; must be >= max(IADDR,DADDR)
STARVE_MAX, 4, consecutive data grants allowed while a fetch is pending; legal range 1..15

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
if_req  in  1  fetch request; held with if_addr stable until if_valid
if_addr  in  IADDR  fetch address
if_rdata  out  WIDTH  fetched word, registered
if_valid  out  1  one-cycle fetch completion pulse
dm_req  in  1  data request; held stable until dm_valid
dm_addr  in  DADDR  data address
dm_wdata  in  WIDTH  store data
dm_wr_en  in  4  byte write enables; 0 = load
dm_rdata  out  WIDTH  load data, registered
dm_valid  out  1  one-cycle data completion pulse
mem_req  out  1  memory request, registered
mem_addr  out  AWIDTH  zero-extended address of granted port
mem_wdata  out  WIDTH  store data (dm only; 0 for fetch)
mem_be  out  4  byte enables (0 for fetch)
mem_ack  in  1  memory completion; mem_rdata valid same cycle
mem_rdata  in  WIDTH  memory read data
stall  out  1  pipeline stall

Behaviour:
- States: IDLE, GNT_I, GNT_D, RESP. Requests are sampled only in IDLE.
- IDLE:
  - dm_req and (if_req==0 or streak<STARVE_MAX) -> GNT_D.
  - else if_req -> GNT_I.
  - else stay in IDLE.
- On entry to GNT_x, mem_req, mem_addr, mem_wdata and mem_be are registered and held until mem_ack.
- GNT_x with mem_ack:
  - capture mem_rdata into x_rdata (stores leave dm_rdata unchanged).
  - go to RESP with x_valid=1 for exactly that one cycle.
  - drop mem_req in that RESP cycle.
- RESP -> IDLE unconditionally. A requester changes its address or drops req the cycle after valid.
- Latency: req seen in IDLE at T -> mem_req at T+1; mem_ack at A -> valid at A+1. Zero-wait memory gives a 3-cycle round trip.
- streak (4-bit counter):
  - +1 on each GNT_D taken while if_req=1.
  - cleared on each GNT_I.
  - holds otherwise.
  - With STARVE_MAX=1, data and fetch alternate under contention.
- stall = (if_req & ~if_valid) | (dm_req & ~dm_valid), combinational.
- mem_ack in IDLE or RESP is ignored; no state change.
- A req deasserted mid-grant (protocol violation) does not abort; the transaction completes and valid still pulses.
- Reset (any state, including mid-transaction) immediately gives:
  - state=IDLE
  - mem_req, mem_addr, mem_wdata, mem_be = 0
  - if_valid, dm_valid = 0
  - if_rdata, dm_rdata = 0
  - streak=0
- The in-flight memory access is abandoned; the memory must tolerate a dropped mem_req.

Optional Feature:
- Macro MEM_ARB_PERF_EN.
- Defined:
  - adds outputs perf_if_grants, perf_dm_grants and perf_stall_cycles, each 32-bit, saturating at all-ones.
  - the grant counters increment on entry to GNT_I/GNT_D; perf_stall_cycles increments on every cycle stall=1.
  - all reset to 0.
- Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package lib_pkg gets:
  - arb_state_t (IDLE, GNT_I, GNT_D, RESP).
  - arb_src_t (SRC_I, SRC_D).
  - the constant STREAK_W=4.
- One sub-module, arb_priority: combinational grant selection from dm_req, if_req, streak and STARVE_MAX.
- The FSM, registers and counters stay in mem_arbiter.

Test Plan:
- Single fetch, if_addr=0x0040, memory acks on the cycle after mem_req with 0x00000013 -> mem_addr=0x0040 and mem_be=0; if_valid pulses one cycle with if_rdata=0x00000013; stall high until that pulse.
- Single store, dm_addr=0x0100, dm_wdata=0xDEADBEEF, dm_wr_en=4'b0011 -> mem_be=4'b0011 and mem_wdata=0xDEADBEEF; dm_valid pulses; dm_rdata keeps its previous value.
- if_req and dm_req both held continuously, STARVE_MAX=4 -> grant order D,D,D,D,I,D,D,D,D,I…; fetch never waits more than 4 data transactions.
- Memory with a 5-cycle ack delay -> mem_req and mem_addr stay stable for all 5 cycles; valid arrives exactly 1 cycle after mem_ack; a spurious mem_ack in IDLE causes no valid.
- Reset asserted 2 cycles into GNT_D -> mem_req=0 and all outputs 0 in the same cycle; after release, a new if_req is granted normally.
- With MEM_ARB_PERF_EN defined: 3 fetches and 2 loads -> perf_if_grants=3, perf_dm_grants=2, and perf_stall_cycles equals the counted stall cycles.
